alu_issue_queue: RTL and testbench

- Upstream feeder for the registered N-bit ALU stage (`ALU_top`).
- Buffers operation requests in a small FIFO and issues at most one per cycle to the ALU, driving its operands, op code, carry-in and enable.
- Tracks when the ALU output register holds a fresh result and presents it to the consumer with valid/ready, together with the carry captured at issue.
- Supports carry chaining for multi-word arithmetic: a chained op takes its carry-in from the previous op's carry-out.

---
 rtl/alu_issue_queue.sv | 64 ++++++
 tb/tb_alu_issue_queue.sv | 116 +++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: FIFO of ALU requests issuing one per cycle, with result handshake and carry chaining
module alu_issue_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_cin,
    input  logic             in_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_cin,
    output logic             alu_enbl,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_cout
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * WIDTH + 5;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          carry_q, empty, push, issue, head_cin, head_chain;
    assign empty    = count == '0;
    assign in_ready = count != FULL;
    assign push     = in_valid && in_ready;
    assign issue    = !empty && (!res_valid || res_ready);
    assign alu_enbl = issue;
    assign head     = empty ? '0 : mem[rd_ptr];
    assign {alu_a, alu_b, alu_op, head_cin, head_chain} = head;
    // an empty head reads as all-zero, so alu_cin is 0 then as well
    assign alu_cin  = head_chain ? carry_q : head_cin;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_a, in_b, in_op, in_cin, in_chain};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            carry_q   <= 1'b0;
            res_cout  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (issue) begin
                rd_ptr   <= rd_ptr + 1'b1;
                carry_q  <= alu_cout;
                res_cout <= alu_cout;
            end
            count     <= count + (AW + 1)'(push) - (AW + 1)'(issue);
            res_valid <= issue || (res_valid && !res_ready);
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: randomized and directed check of alu_issue_queue against a queue-based model
module tb_alu_issue_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic             cin;
        logic             chain;
    } ent_t;
    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, in_cin, in_chain;
    logic [WIDTH-1:0] in_a, in_b, alu_a, alu_b;
    logic [2:0]       in_op, alu_op;
    logic             alu_cin, alu_enbl, alu_cout, res_valid, res_ready, res_cout;
    logic [WIDTH:0]   alu_sum;
    int               n_chk = 0;
    int               n_fail = 0;
    ent_t             q[$];
    logic             m_carry = 1'b0;
    logic             m_rv = 1'b0;
    logic             m_rc = 1'b0;
    alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_chain(in_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_enbl(alu_enbl), .alu_cout(alu_cout), .res_valid(res_valid),
        .res_ready(res_ready), .res_cout(res_cout)
    );
    always #5 clk = ~clk;
    // ALU stub: carry-out of a + b + cin on whatever the queue is driving
    assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_cin};
    assign alu_cout = alu_sum[WIDTH];
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic cyc(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] op, input logic ci, input logic ch,
                       input logic rr, input logic r);
        logic             rdy, iss, hc, co;
        logic [WIDTH:0]   s;
        ent_t             h;
        in_valid = v; in_a = a; in_b = b; in_op = op; in_cin = ci; in_chain = ch;
        res_ready = rr; rst = r;
        @(negedge clk);
        rdy = q.size() < DEPTH;
        iss = q.size() > 0 && (!m_rv || rr);
        h   = q.size() > 0 ? q[0] : '{default: '0};
        hc  = h.chain ? m_carry : h.cin;
        s   = {1'b0, h.a} + {1'b0, h.b} + {{WIDTH{1'b0}}, hc};
        co  = s[WIDTH];
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("alu_enbl", 64'(alu_enbl), 64'(iss));
        chk("res_valid", 64'(res_valid), 64'(m_rv));
        chk("res_cout", 64'(res_cout), 64'(m_rc));
        chk("alu_a", 64'(alu_a), 64'(h.a));
        chk("alu_b", 64'(alu_b), 64'(h.b));
        chk("alu_op", 64'(alu_op), 64'(h.op));
        chk("alu_cin", 64'(alu_cin), 64'(hc));
        @(posedge clk);
        if (r) begin
            q.delete();
            m_carry = 1'b0; m_rv = 1'b0; m_rc = 1'b0;
        end else begin
            if (iss) begin
                void'(q.pop_front());
                m_carry = co; m_rc = co;
            end
            m_rv = iss || (m_rv && !rr);
            if (v && rdy) q.push_back('{a: a, b: b, op: op, cin: ci, chain: ch});
        end
        #1;
    endtask
    task automatic idle(input logic rr, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, rr, 1'b0);
    endtask
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_cin = 1'b0; in_chain = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(1'b1, 1);
        cyc(1'b1, 32'd5, 32'd3, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 3);
        cyc(1'b1, 32'hFFFFFFFF, 32'd1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'd0, 32'd0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 3);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'(i + 10), 32'(i), 3'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 3);
        idle(1'b1, 1);
        idle(1'b0, 2);
        idle(1'b1, 4);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 32'(i) * 32'h11111111, 32'hFFFFFFF0 + 32'(i), 3'(i), i[0], i[1], 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 8);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hFFFFFFFF, 32'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 32'd7, 32'd8, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 3);
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] a;
            a = ($urandom_range(3) == 0) ? 32'hFFFFFFFF : WIDTH'($urandom);
            cyc($urandom_range(9) < 7, a, WIDTH'($urandom_range(3)), 3'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(9) < 6, $urandom_range(199) == 0);
        end
        idle(1'b1, 8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
